// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port pipelined RAM: address sizing,
// read-during-write mode codes and the clear sequencer state encoding.
package ram_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_2p_rdpipe.sv
// Read data/valid pipeline for one RAM port; the last stage only loads on a
// valid beat so q holds its previous value between reads.
module ram_2p_rdpipe #(
  parameter int W      = 32,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] q,
  output logic         qv
);

  logic [RD_LAT-1:0] v;
  logic [W-1:0]      d [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < RD_LAT; k++) d[k] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int k = 1; k < RD_LAT; k++) begin
        v[k] <= v[k-1];
        if (v[k-1]) d[k] <= d[k-1];
      end
    end
  end

  assign q  = d[RD_LAT-1];
  assign qv = v[RD_LAT-1];

endmodule

// File: rtl/ram_2p_pipe.sv
// Single-clock true dual-port RAM with byte enables, configurable read latency,
// selectable read-during-write behaviour and a post-reset clear sequencer.
//   state | meaning
//   CLEAR | zeroing the array one word per cycle (skipped when INIT_CLEAR=0)
//   RUN   | array usable, user accesses accepted
module ram_2p_pipe import ram_pkg::*; #(
  parameter  int BYTES      = 4,
  parameter  int BYTE_W     = 8,
  parameter  int DEPTH      = 256,
  parameter  int RD_LAT     = 1,
  parameter  int RDW_MODE   = 0,
  parameter  int INIT_CLEAR = 1,
  localparam int AWIDTH     = clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      init_done,
  input  logic                      ce0,
  input  logic                      we0,
  input  logic [BYTES-1:0]          be0,
  input  logic [AWIDTH-1:0]         address0,
  input  logic [BYTES*BYTE_W-1:0]   d0,
  output logic [BYTES*BYTE_W-1:0]   q0,
  output logic                      qv0,
  input  logic                      ce1,
  input  logic                      we1,
  input  logic [BYTES-1:0]          be1,
  input  logic [AWIDTH-1:0]         address1,
  input  logic [BYTES*BYTE_W-1:0]   d1,
  output logic [BYTES*BYTE_W-1:0]   q1,
  output logic                      qv1
);

  localparam int                W         = BYTES * BYTE_W;
  localparam logic [AWIDTH:0]   DEPTH_X   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  clr_state_e        state, state_nxt;
  logic [AWIDTH-1:0] clr_addr, clr_addr_nxt;
  logic              clr_we;

  logic [W-1:0] mem [DEPTH];

  logic         in0, in1, acc0, acc1, wr0, wr1;
  logic [W-1:0] rd0, rd1;

  assign init_done = (state == RUN);

  assign in0  = {1'b0, address0} < DEPTH_X;
  assign in1  = {1'b0, address1} < DEPTH_X;
  assign acc0 = init_done & ce0;
  assign acc1 = init_done & ce1;
  assign wr0  = acc0 & we0 & in0;
  assign wr1  = acc1 & we1 & in1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    clr_we       = 1'b0;
    case (state)
      CLEAR: begin
        if (INIT_CLEAR == 0) begin
          state_nxt = RUN;
        end else begin
          clr_we       = 1'b1;
          clr_addr_nxt = clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state_nxt    = RUN;
            clr_addr_nxt = '0;
          end
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // Port 1 lanes are written first so a lane enabled on both ports ends up
  // holding port 0 data.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < BYTES; i++)
        if (wr1 && be1[i]) mem[address1][i*BYTE_W +: BYTE_W] <= d1[i*BYTE_W +: BYTE_W];
      for (int i = 0; i < BYTES; i++)
        if (wr0 && be0[i]) mem[address0][i*BYTE_W +: BYTE_W] <= d0[i*BYTE_W +: BYTE_W];
    end
  end

  function automatic logic [W-1:0] merge(input logic [W-1:0] base, input logic hit,
                                         input logic [BYTES-1:0] be, input logic [W-1:0] d);
    logic [W-1:0] r;
    r = base;
    for (int i = 0; i < BYTES; i++)
      if (hit && be[i]) r[i*BYTE_W +: BYTE_W] = d[i*BYTE_W +: BYTE_W];
    return r;
  endfunction

  // Write-first forwarding applies the same lane priority as the array write.
  always_comb begin
    rd0 = in0 ? mem[address0] : '0;
    rd1 = in1 ? mem[address1] : '0;
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      rd0 = merge(rd0, wr1 && (address1 == address0), be1, d1);
      rd0 = merge(rd0, wr0, be0, d0);
      rd1 = merge(rd1, wr1, be1, d1);
      rd1 = merge(rd1, wr0 && (address0 == address1), be0, d0);
    end
  end

  ram_2p_rdpipe #(.W(W), .RD_LAT(RD_LAT)) u_rdpipe0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (acc0),
    .in_data  (rd0),
    .q        (q0),
    .qv       (qv0)
  );

  ram_2p_rdpipe #(.W(W), .RD_LAT(RD_LAT)) u_rdpipe1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (acc1),
    .in_data  (rd1),
    .q        (q1),
    .qv       (qv1)
  );

endmodule
